// File: rtl/lifo_ctrl_pkg.sv
// Shared encodings for the LIFO request arbiter: FSM states, op codes and
// a helper that sizes requester-index fields.
package lifo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: scans upward from ptr with wrap and
// returns the first active request as a one-hot grant plus its index.
module rr_arbiter
  import lifo_ctrl_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  // First requester at or above ptr (modulo NREQ) wins.
  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    for (int k = 0; k < NREQ; k++) begin
      c = int'(ptr) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!valid && req[IW'(c)]) begin
        valid           = 1'b1;
        idx             = IW'(c);
        grant[IW'(c)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lifo_arbiter.sv
// Serialises push/pop requests from NREQ requesters onto one stack.
// Each grant runs IDLE -> ISSUE (stack strobe) -> RESP (ack pulse).
module lifo_arbiter
  import lifo_ctrl_pkg::*;
#(
  parameter int BITWIDTH = 5,
  parameter int DEPTH    = 4,
  parameter int NREQ     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          op,
  input  logic [NREQ*BITWIDTH-1:0] wdata,
  output logic [NREQ-1:0]          ack,
  output logic                     err,
  output logic [BITWIDTH-1:0]      rdata,
  output logic                     busy,
  output logic [DEPTH:0]           count,
  output logic                     lifo_wEn,
  output logic                     lifo_rEn,
  output logic [BITWIDTH-1:0]      lifo_dIn,
  input  logic                     lifo_full,
  input  logic                     lifo_empty,
  input  logic [BITWIDTH-1:0]      lifo_dOut
);

  localparam int IW = idx_width(NREQ);
  localparam logic [DEPTH:0] CNT_MAX  = (DEPTH+1)'(2**DEPTH);
  localparam logic [DEPTH:0] CNT_ONE  = (DEPTH+1)'(1);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NREQ-1);
  localparam logic [IW-1:0]  IDX_ONE  = IW'(1);

  state_e                state_q, state_d;
  logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  op_q, op_d;
  logic [BITWIDTH-1:0]   data_q, data_d;
  logic [BITWIDTH-1:0]   rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [DEPTH:0]        count_q, count_d;

  logic [NREQ-1:0]       gnt;
  logic [IW-1:0]         gnt_idx;
  logic                  gnt_valid;
  logic                  gnt_op;
  logic [BITWIDTH-1:0]   gnt_data;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (req),
    .ptr   (rr_ptr_q),
    .grant (gnt),
    .idx   (gnt_idx),
    .valid (gnt_valid)
  );

  // Pick the winning requester's op and data through the one-hot grant.
  always_comb begin
    gnt_op   = 1'b0;
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_op   = op[i];
        gnt_data = wdata[i*BITWIDTH +: BITWIDTH];
      end
    end
  end

  // Next-state, stack strobes and occupancy bookkeeping.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    op_d     = op_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    count_d  = count_q;
    lifo_wEn = 1'b0;
    lifo_rEn = 1'b0;
    lifo_dIn = '0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          idx_d    = gnt_idx;
          op_d     = gnt_op;
          data_d   = gnt_data;
          rdata_d  = '0;
          err_d    = 1'b0;
          rr_ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_ONE;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        state_d = RESP;
        rdata_d = '0;
        err_d   = 1'b0;
        if (op_q == OP_PUSH) begin
          if (!lifo_full) begin
            lifo_wEn = 1'b1;
            lifo_dIn = data_q;
            if (count_q != CNT_MAX) count_d = count_q + CNT_ONE;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          if (!lifo_empty) begin
            lifo_rEn = 1'b1;
            rdata_d  = lifo_dOut;
            if (count_q != '0) count_d = count_q - CNT_ONE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      idx_q    <= '0;
      op_q     <= 1'b0;
      data_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      op_q     <= op_d;
      data_q   <= data_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      count_q  <= count_d;
    end
  end

  // Ack is decoded per requester and only ever high in RESP.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
    assign ack[gi] = (state_q == RESP) && (idx_q == IW'(gi));
  end

  assign err   = (state_q == RESP) && err_q;
  assign rdata = (state_q == RESP) ? rdata_q : '0;
  assign busy  = (state_q != IDLE);
  assign count = count_q;

endmodule

// File: tb/tb_lifo_arbiter.sv
// Bench for lifo_arbiter: a behavioural stack sits on the stack port, a
// queue-based reference model predicts acks and strobes, and a monitor
// compares DUT outputs against the predictions as they appear.
module tb_lifo_arbiter;

  localparam int BW  = 5;
  localparam int DP  = 4;
  localparam int NR  = 4;
  localparam int CAP = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR-1:0]     op;
  logic [NR*BW-1:0]  wdata;
  logic [NR-1:0]     ack;
  logic              err;
  logic [BW-1:0]     rdata;
  logic              busy;
  logic [DP:0]       count;
  logic              lifo_wEn, lifo_rEn;
  logic [BW-1:0]     lifo_dIn;
  logic              lifo_full, lifo_empty;
  logic [BW-1:0]     lifo_dOut;

  lifo_arbiter #(.BITWIDTH(BW), .DEPTH(DP), .NREQ(NR)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .wdata(wdata),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy), .count(count),
    .lifo_wEn(lifo_wEn), .lifo_rEn(lifo_rEn), .lifo_dIn(lifo_dIn),
    .lifo_full(lifo_full), .lifo_empty(lifo_empty), .lifo_dOut(lifo_dOut)
  );

  always #5 clk = ~clk;

  // Stack attached to the arbiter, reset by the same rst.
  logic [BW-1:0] smem [CAP];
  int sp = 0;
  assign lifo_full  = (sp == CAP);
  assign lifo_empty = (sp == 0);
  assign lifo_dOut  = (sp == 0) ? '0 : smem[sp-1];
  always @(posedge clk) begin
    if (rst) sp <= 0;
    else if (lifo_wEn && sp < CAP) begin
      smem[sp] <= lifo_dIn;
      sp <= sp + 1;
    end else if (lifo_rEn && sp > 0) sp <= sp - 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          idx;
    bit          err;
    logic [BW-1:0] rdata;
    int          cnt;
    int          gap;
  } exp_t;

  typedef struct {
    bit          push;
    logic [BW-1:0] data;
  } stb_t;

  exp_t exp_q[$];
  stb_t stb_q[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  // Reference model state: stack contents and round-robin start point.
  logic [BW-1:0] m_stack[$];
  int m_ptr = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: every cycle, match strobes and acks against predictions.
  initial begin
    exp_t e;
    stb_t s;
    int last_ack;
    last_ack = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("strobe_excl", lifo_wEn & lifo_rEn, 0);
        if (lifo_wEn || lifo_rEn) begin
          if (stb_q.size() == 0) chk("unexpected_strobe", 1, 0);
          else begin
            s = stb_q.pop_front();
            chk("strobe_dir", lifo_wEn, s.push);
            if (s.push) chk("lifo_dIn", lifo_dIn, s.data);
          end
        end
        if (ack != 0) begin
          if (exp_q.size() == 0) chk("unexpected_ack", ack, 0);
          else begin
            e = exp_q.pop_front();
            chk("ack_vec", ack, 1 << e.idx);
            chk("ack_err", err, e.err);
            chk("ack_rdata", rdata, e.rdata);
            chk("ack_count", count, e.cnt);
            if (e.gap != 0) chk("ack_gap", cyc - last_ack, e.gap);
          end
          last_ack = cyc;
        end else begin
          chk("idle_err", err, 0);
          chk("idle_rdata", rdata, 0);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_wEn", lifo_wEn, 0);
    chk("rst_rEn", lifo_rEn, 0);
    rst = 1'b0;
    m_stack.delete();
    m_ptr = 0;
    mon_en = 1'b1;
  endtask

  // Predict the serve order for a set of simultaneously raised requests,
  // then drive them and drop each req as its ack arrives.
  task automatic batch(input logic [NR-1:0] mask, input logic [NR-1:0] ops,
                       input logic [NR*BW-1:0] data);
    logic [NR-1:0] pend;
    exp_t e;
    stb_t s;
    int g, n, c;
    bit first;
    pend = mask;
    first = 1'b1;
    while (pend != 0) begin
      g = -1;
      for (int k = 0; k < NR; k++) begin
        c = (m_ptr + k) % NR;
        if (g < 0 && pend[c]) g = c;
      end
      e.idx = g;
      e.gap = first ? 0 : 3;
      e.err = 1'b0;
      e.rdata = '0;
      first = 1'b0;
      if (ops[g]) begin
        if (m_stack.size() == CAP) e.err = 1'b1;
        else begin
          m_stack.push_back(data[g*BW +: BW]);
          s.push = 1'b1;
          s.data = data[g*BW +: BW];
          stb_q.push_back(s);
        end
      end else begin
        if (m_stack.size() == 0) e.err = 1'b1;
        else begin
          e.rdata = m_stack.pop_back();
          s.push = 1'b0;
          s.data = '0;
          stb_q.push_back(s);
        end
      end
      e.cnt = m_stack.size();
      exp_q.push_back(e);
      pend[g] = 1'b0;
      m_ptr = (g + 1) % NR;
    end
    op = ops;
    wdata = data;
    req = mask;
    n = 0;
    while (req != 0 && n < 60) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < NR; i++) if (ack[i]) req[i] = 1'b0;
    end
    if (req != 0) chk("batch_timeout", req, 0);
    req = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    op = '0;
    wdata = '0;
    @(negedge clk);
    do_reset();

    // Single push from requester 0, then pop from requester 2.
    batch(4'b0001, 4'b0001, {15'd0, 5'h15});
    chk("single_push_count", count, 1);
    batch(4'b0100, 4'b0000, '0);
    chk("single_pop_count", count, 0);

    // Fairness from a fresh pointer, then pops come back reversed.
    do_reset();
    batch(4'b1111, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1});
    for (int k = 0; k < 4; k++) batch(4'(1 << k), 4'b0000, '0);

    // Underflow on an empty stack.
    batch(4'b0010, 4'b0000, '0);
    chk("underflow_count", count, 0);

    // Overflow: fill, then one push too many.
    do_reset();
    for (int k = 0; k < CAP; k++) batch(4'b0001, 4'b0001, NR*BW'($urandom));
    chk("full_count", count, CAP);
    chk("full_flag", lifo_full, 1);
    batch(4'b1000, 4'b1000, {5'h1f, 15'd0});
    chk("overflow_count", count, CAP);

    // Abort: reset lands in the ISSUE cycle of a push.
    do_reset();
    op = 4'b0001;
    wdata = {15'd0, 5'd9};
    req = 4'b0001;
    stb_q.push_back('{push: 1'b1, data: 5'd9});
    @(negedge clk);
    chk("abort_busy_issue", busy, 1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    m_stack.delete();
    m_ptr = 0;
    chk("abort_busy", busy, 0);
    chk("abort_count", count, 0);
    chk("abort_ack", ack, 0);
    repeat (3) @(negedge clk);

    // Randomised traffic: push-heavy phase then pop-heavy phase.
    for (int it = 0; it < 60; it++) begin
      logic [NR-1:0] m, o;
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++)
        o[i] = (it < 30) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      batch(m, o, NR*BW'($urandom));
      chk("rand_count", count, m_stack.size());
    end

    repeat (3) @(negedge clk);
    chk("exp_left", exp_q.size(), 0);
    chk("stb_left", stb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lifo_arbiter.md
LIFO_ARBITER -- requirements
Module: lifo_arbiter

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 5, giving the data word width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning stack capacity is 2**DEPTH entries.
REQ-003 The block SHALL have parameter NREQ, default 4, giving the number of requesters.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, NREQ bits: per-requester request, held high until the matching ack.
REQ-007 The block SHALL have port op, input, NREQ bits: per-requester operation, 1=push and 0=pop, held stable with req.
REQ-008 The block SHALL have port wdata, input, NREQ*BITWIDTH bits: push data; requester i uses slice [i*BITWIDTH +: BITWIDTH].
REQ-009 The block SHALL have port ack, output, NREQ bits: one-cycle completion pulse to the served requester.
REQ-010 The block SHALL have port err, output, 1 bit: valid with ack; 1 means the request was rejected (push when full, pop when empty).
REQ-011 The block SHALL have port rdata, output, BITWIDTH bits: valid with ack on a successful pop, otherwise 0.
REQ-012 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-013 The block SHALL have port count, output, DEPTH+1 bits: current stack occupancy, 0..2**DEPTH.
REQ-014 The block SHALL have ports lifo_wEn and lifo_rEn, outputs, 1 bit each: push and pop strobes to the stack.
REQ-015 The block SHALL have port lifo_dIn, output, BITWIDTH bits: data to the stack.
REQ-016 The block SHALL have ports lifo_full and lifo_empty, inputs, 1 bit each: stack status flags.
REQ-017 The block SHALL have port lifo_dOut, input, BITWIDTH bits: combinational top-of-stack value.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE and RESP; every transition is taken on a clock edge.
REQ-019 In IDLE with any req high, the block SHALL select one requester round-robin, starting the search at rr_ptr and going upward with wrap; it SHALL latch index, op and data, then go to ISSUE.
REQ-020 On each grant, rr_ptr SHALL become (granted index + 1) mod NREQ.
REQ-021 In ISSUE on a push with lifo_full=0, the block SHALL drive lifo_wEn=1 and lifo_dIn=latched data for exactly that cycle, and increment count.
REQ-022 In ISSUE on a pop with lifo_empty=0, the block SHALL drive lifo_rEn=1, register lifo_dOut into rdata in the same cycle, and decrement count.
REQ-023 In ISSUE on a push with lifo_full=1, or a pop with lifo_empty=1, the block SHALL assert no strobe, leave count unchanged and set the error flag.
REQ-024 ISSUE SHALL always go to RESP, and RESP SHALL always go to IDLE.
REQ-025 In RESP the block SHALL pulse ack[granted]=1 for one cycle, with err and rdata valid in that cycle.
REQ-026 Latency SHALL be as follows: request sampled in IDLE at edge N, strobe during cycle N+1, ack during cycle N+2; the next grant is no earlier than edge N+3.
REQ-027 lifo_wEn and lifo_rEn SHALL never be high in the same cycle.
REQ-028 Outside ISSUE, the block SHALL hold both strobes low.
REQ-029 Outside RESP, the block SHALL hold ack, err and rdata at 0.
REQ-030 count SHALL saturate: it never exceeds 2**DEPTH and never goes below 0.
REQ-031 A requester dropping req before its grant SHALL be ignored; once granted, the operation SHALL complete regardless of req.

Reset
REQ-032 When rst=1 at an edge, the block SHALL set state=IDLE, rr_ptr=0, count=0 and clear the latched index/op/data and rdata.
REQ-033 In the cycle after reset, all outputs SHALL be 0.
REQ-034 Reset during ISSUE or RESP SHALL abort the operation, and no ack SHALL be issued for it.
REQ-035 lifo_arbiter SHALL be reset together with the stack from the same rst.

Structure
REQ-036 Package lifo_ctrl_pkg SHALL hold the FSM state encoding (IDLE=0, ISSUE=1, RESP=2) and the op encoding constants (OP_PUSH=1, OP_POP=0).
REQ-037 The round-robin selection SHALL be the sub-module rr_arbiter, taking NREQ bits of request plus the pointer and returning a one-hot grant plus the index, purely combinational.
REQ-038 All other logic SHALL reside in lifo_arbiter.

Verification
Benches use BITWIDTH=5, DEPTH=4, NREQ=4, connected to the team's stack.
REQ-039 Reset: hold rst high for 2 cycles -> ack=0, err=0, rdata=0, busy=0, count=0, no strobes.
REQ-040 Single push and pop: req[0] push 5'h15 -> lifo_wEn one cycle after the grant edge with lifo_dIn=5'h15, then ack[0]=1, err=0, count=1; then req[2] pop -> ack[2], rdata=5'h15, count=0.
REQ-041 Fairness: all four requesters push simultaneously (data 1, 2, 3, 4) -> acks in order 0, 1, 2, 3, spaced 3 cycles apart; subsequent pops return 4, 3, 2, 1.
REQ-042 Underflow: pop at count=0 -> no lifo_rEn, ack with err=1 and rdata=0, count stays 0.
REQ-043 Overflow: 16 pushes -> count=16 and lifo_full=1; the 17th push -> no lifo_wEn, err=1, count=16.
REQ-044 Abort: assert rst in the ISSUE cycle of a push -> no ack, busy=0 next cycle, count=0.
